flash_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-switch LED flasher.
- Each of CH channels takes one raw switch input and drives one LED output.
- A shared mode input selects one of four behaviours: follow, blink-while-held, fixed-length burst, or toggle latch.
- The block sits between the board switch pins and the LED pins. Switch inputs are asynchronous to clk and are synchronised internally.

---
 rtl/flash_multi.sv | 242 ++++++++++++++++++++++++
 tb/tb_flash_multi.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/flash_multi.sv
// flash_multi: CH-channel switch-to-LED flasher with follow, blink, burst and toggle modes.
// Optional debounce stage on each synchronised switch, enabled by `define FLASH_DEBOUNCE_EN.
module flash_multi #(
  parameter int CH         = 4,
  parameter int ON_CYCLES  = 3,
  parameter int OFF_CYCLES = 2,
`ifdef FLASH_DEBOUNCE_EN
  parameter int DEB_CYCLES = 8,
`endif
  parameter int BURST      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] ld,
  output logic [CH-1:0] busy
);

  localparam int PMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int PW   = $clog2(PMAX) + 1;
  localparam int BW   = $clog2(BURST) + 1;
  localparam logic [PW-1:0] ON_LAST    = PW'(ON_CYCLES - 1);
  localparam logic [PW-1:0] OFF_LAST   = PW'(OFF_CYCLES - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

  localparam logic [1:0] M_FOLLOW = 2'b00;
  localparam logic [1:0] M_BLINK  = 2'b01;
  localparam logic [1:0] M_BURST  = 2'b10;
  localparam logic [1:0] M_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ON   = 2'b01,
    S_OFF  = 2'b10
  } state_t;

  logic [CH-1:0] sync1_q;
  logic [CH-1:0] sw_s_q;
  logic [CH-1:0] sw_d_q;
  logic [CH-1:0] sw_f;
  logic [1:0]    mode_q;
  logic          mode_chg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sw_s_q  <= '0;
      sw_d_q  <= '0;
      mode_q  <= M_FOLLOW;
    end else begin
      sync1_q <= sw;
      sw_s_q  <= sync1_q;
      sw_d_q  <= sw_f;
      mode_q  <= mode;
    end
  end

  // A mode edge flushes every channel; the new mode is acted on one edge later.
  assign mode_chg = (mode != mode_q);

`ifdef FLASH_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  genvar gd;
  for (gd = 0; gd < CH; gd++) begin : g_deb
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          lvl_q, lvl_d;

    always_comb begin
      dcnt_d = '0;
      lvl_d  = lvl_q;
      if (sw_s_q[gd] != lvl_q) begin
        if (dcnt_q == DEB_LAST) begin
          lvl_d = sw_s_q[gd];
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dcnt_q <= '0;
        lvl_q  <= 1'b0;
      end else begin
        dcnt_q <= dcnt_d;
        lvl_q  <= lvl_d;
      end
    end

    assign sw_f[gd] = lvl_q;
  end
`else
  assign sw_f = sw_s_q;
`endif

  genvar gi;
  for (gi = 0; gi < CH; gi++) begin : g_ch
    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          ld_q, ld_d;
    logic          busy_q, busy_d;
    logic          lvl;
    logic          rise;

    assign lvl  = sw_f[gi];
    assign rise = sw_f[gi] & ~sw_d_q[gi];

    always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      bcnt_d  = bcnt_q;
      ld_d    = ld_q;
      if (mode_chg) begin
        state_d = S_IDLE;
        pcnt_d  = '0;
        bcnt_d  = '0;
        ld_d    = 1'b0;
      end else begin
        case (mode_q)
          M_FOLLOW: begin
            state_d = S_IDLE;
            pcnt_d  = '0;
            bcnt_d  = '0;
            ld_d    = lvl;
          end
          M_TOGGLE: begin
            state_d = S_IDLE;
            pcnt_d  = '0;
            bcnt_d  = '0;
            if (rise) ld_d = ~ld_q;
          end
          M_BLINK: begin
            bcnt_d = '0;
            if (!lvl) begin
              state_d = S_IDLE;
              pcnt_d  = '0;
              ld_d    = 1'b0;
            end else begin
              case (state_q)
                S_IDLE: begin
                  state_d = S_ON;
                  pcnt_d  = '0;
                  ld_d    = 1'b1;
                end
                S_ON: begin
                  if (pcnt_q == ON_LAST) begin
                    state_d = S_OFF;
                    pcnt_d  = '0;
                    ld_d    = 1'b0;
                  end else begin
                    pcnt_d = pcnt_q + PW'(1);
                  end
                end
                S_OFF: begin
                  if (pcnt_q == OFF_LAST) begin
                    state_d = S_ON;
                    pcnt_d  = '0;
                    ld_d    = 1'b1;
                  end else begin
                    pcnt_d = pcnt_q + PW'(1);
                  end
                end
                default: begin
                  state_d = S_IDLE;
                  pcnt_d  = '0;
                  ld_d    = 1'b0;
                end
              endcase
            end
          end
          default: begin
            // Burst: rises are only looked at from IDLE, so any that land mid-burst are lost.
            case (state_q)
              S_IDLE: begin
                if (rise) begin
                  state_d = S_ON;
                  pcnt_d  = '0;
                  bcnt_d  = '0;
                  ld_d    = 1'b1;
                end
              end
              S_ON: begin
                if (pcnt_q == ON_LAST) begin
                  state_d = S_OFF;
                  pcnt_d  = '0;
                  ld_d    = 1'b0;
                end else begin
                  pcnt_d = pcnt_q + PW'(1);
                end
              end
              S_OFF: begin
                if (pcnt_q != OFF_LAST) begin
                  pcnt_d = pcnt_q + PW'(1);
                end else if (bcnt_q == BURST_LAST) begin
                  state_d = S_IDLE;
                  pcnt_d  = '0;
                  bcnt_d  = '0;
                end else begin
                  state_d = S_ON;
                  pcnt_d  = '0;
                  bcnt_d  = bcnt_q + BW'(1);
                  ld_d    = 1'b1;
                end
              end
              default: begin
                state_d = S_IDLE;
                pcnt_d  = '0;
                bcnt_d  = '0;
                ld_d    = 1'b0;
              end
            endcase
          end
        endcase
      end
      busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= S_IDLE;
        pcnt_q  <= '0;
        bcnt_q  <= '0;
        ld_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        pcnt_q  <= pcnt_d;
        bcnt_q  <= bcnt_d;
        ld_q    <= ld_d;
        busy_q  <= busy_d;
      end
    end

    assign ld[gi]   = ld_q;
    assign busy[gi] = busy_q;
  end

endmodule

// File: tb/tb_flash_multi.sv
// Self-checking bench for flash_multi: directed vector table, hand sequences and a
// randomized run compared against a sequence-position reference model.
module tb_flash_multi;
  localparam int CH  = 4;
  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int BST = 2;
  localparam int PER = ON + OFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [CH-1:0] sw = '0;
  logic [CH-1:0] ld;
  logic [CH-1:0] busy;

  int checks = 0;
  int failures = 0;

  flash_multi #(
    .CH(CH), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .BURST(BST)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .sw(sw), .ld(ld), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: pos[c] is the cycle index inside the running blink/burst, -1 when idle.
  logic [CH-1:0] m_s1, m_s, m_d, m_ld, m_busy;
  logic [1:0]    m_mode;
  int            pos [CH];

  task automatic model_reset();
    m_s1 = '0; m_s = '0; m_d = '0; m_ld = '0; m_busy = '0; m_mode = 2'b00;
    for (int c = 0; c < CH; c++) pos[c] = -1;
  endtask

  task automatic model_step(input logic [CH-1:0] swv, input logic [1:0] mv);
    for (int c = 0; c < CH; c++) begin
      logic lvl, rise;
      lvl  = m_s[c];
      rise = m_s[c] & ~m_d[c];
      if (mv != m_mode) begin
        pos[c] = -1;
        m_ld[c] = 1'b0;
      end else begin
        case (m_mode)
          2'b00: begin pos[c] = -1; m_ld[c] = lvl; end
          2'b01: begin
            pos[c] = lvl ? (pos[c] + 1) % PER : -1;
            m_ld[c] = (pos[c] >= 0) && (pos[c] < ON);
          end
          2'b10: begin
            if (pos[c] >= 0) begin
              pos[c]++;
              if (pos[c] == BST * PER) pos[c] = -1;
            end else if (rise) begin
              pos[c] = 0;
            end
            m_ld[c] = (pos[c] >= 0) && ((pos[c] % PER) < ON);
          end
          default: begin pos[c] = -1; if (rise) m_ld[c] = ~m_ld[c]; end
        endcase
      end
      m_busy[c] = (pos[c] >= 0);
    end
    m_mode = mv;
    m_d  = m_s;
    m_s  = m_s1;
    m_s1 = swv;
  endtask

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, step the model at the rising edge, compare at the next fall.
  task automatic cyc(input logic [CH-1:0] swv, input logic [1:0] mv);
    sw = swv;
    mode = mv;
    @(posedge clk);
    model_step(swv, mv);
    @(negedge clk);
    check("model_ld", ld, m_ld);
    check("model_busy", busy, m_busy);
    $display("cyc t=%0t mode=%b sw=%b ld=%b busy=%b", $time, mv, swv, ld, busy);
  endtask

  typedef struct {
    logic [1:0]    mode;
    logic [CH-1:0] sw;
    logic [CH-1:0] exp_ld;
    logic [CH-1:0] exp_busy;
  } vec_t;

  function automatic vec_t mk(input logic s0, input logic l0, input logic b0);
    vec_t v;
    v.mode = 2'b10;
    v.sw = {{(CH-1){1'b0}}, s0};
    v.exp_ld = {{(CH-1){1'b0}}, l0};
    v.exp_busy = {{(CH-1){1'b0}}, b0};
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    // Burst on channel 0 with a second, ignored pulse at edges 6-7.
    tbl[0]  = mk(1, 0, 0); tbl[1]  = mk(1, 0, 0); tbl[2]  = mk(0, 1, 1);
    tbl[3]  = mk(0, 1, 1); tbl[4]  = mk(0, 1, 1); tbl[5]  = mk(1, 0, 1);
    tbl[6]  = mk(1, 0, 1); tbl[7]  = mk(0, 1, 1); tbl[8]  = mk(0, 1, 1);
    tbl[9]  = mk(0, 1, 1); tbl[10] = mk(0, 0, 1); tbl[11] = mk(0, 0, 1);
    tbl[12] = mk(0, 0, 0); tbl[13] = mk(0, 0, 0); tbl[14] = mk(0, 0, 0);

    model_reset();
    sw = '1;
    mode = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_ld", ld, '0);
      check("reset_busy", busy, '0);
    end
    sw = '0;
    mode = 2'b00;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) cyc('0, 2'b10);
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].sw, tbl[i].mode);
      check($sformatf("tbl%0d_ld", i), ld, tbl[i].exp_ld);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
    end

    // Blink on channel 1: held 14 cycles, then released mid-pattern.
    for (int i = 0; i < 3; i++) cyc('0, 2'b01);
    for (int i = 0; i < 14; i++) cyc(4'b0010, 2'b01);
    for (int i = 0; i < 3; i++) cyc('0, 2'b01);
    check("blink_release_ld", ld, '0);
    check("blink_release_busy", busy, '0);

    // Toggle: three 4-high/4-low pulses on channel 0.
    for (int i = 0; i < 3; i++) cyc('0, 2'b11);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) cyc(4'b0001, 2'b11);
      for (int i = 0; i < 4; i++) cyc('0, 2'b11);
      check($sformatf("toggle%0d", p), ld, (p % 2 == 0) ? 4'b0001 : 4'b0000);
    end

    // Mode change mid-burst with sw[0] still held: flush, then blinking resumes.
    for (int i = 0; i < 3; i++) cyc('0, 2'b10);
    for (int i = 0; i < 5; i++) cyc(4'b0001, 2'b10);
    check("pre_switch_busy", busy, 4'b0001);
    cyc(4'b0001, 2'b01);
    check("switch_ld", ld, '0);
    check("switch_busy", busy, '0);
    cyc(4'b0001, 2'b01);
    check("resume_ld", ld, 4'b0001);
    for (int i = 0; i < 6; i++) cyc(4'b0001, 2'b01);

    // Asynchronous reset in the middle of a cycle while blinking.
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ld", ld, '0);
    check("async_rst_busy", busy, '0);
    model_reset();
    sw = '0;
    mode = 2'b00;
    @(negedge clk);
    rst = 1'b1;

    // Randomized run: sparse switch flips and occasional mode changes.
    begin
      logic [CH-1:0] rsw;
      logic [1:0]    rmode;
      rsw = '0;
      rmode = 2'b00;
      for (int n = 0; n < 1500; n++) begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range(0, 5) == 0) rsw[c] = ~rsw[c];
        if ($urandom_range(0, 59) == 0) rmode = 2'($urandom_range(0, 3));
        cyc(rsw, rmode);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
